// File: rtl/trdb_packet_encapsulator.sv
// Trace packet encapsulator: buffers {payload, length} packets in a small FIFO
// and serialises each one as header [+ source-ID] + payload bytes on a
// ready/valid byte stream.
// Build option: define TRDB_ENCAP_SRCID_EN to emit the SRC_ID byte after the header.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | nothing presented; waiting for a buffered packet
// S_HEADER  | header byte {0, FLOW, length} presented
// S_SRCID   | SRC_ID byte presented (only with TRDB_ENCAP_SRCID_EN)
// S_PAYLOAD | payload byte cnt_q of the head packet presented
module trdb_packet_encapsulator #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter logic [1:0]  FLOW       = 2'b00,
  parameter logic [7:0]  SRC_ID     = 8'h00
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         packet_valid_i,
  input  logic [247:0] packet_payload_i,
  input  logic [4:0]   payload_length_i,
  output logic [7:0]   byte_o,
  output logic         byte_valid_o,
  input  logic         byte_ready_i,
  output logic         last_o,
  output logic         overflow_o,
  output logic [15:0]  drop_count_o,
  output logic         busy_o
);

  localparam int unsigned AW      = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] ONE_C   = (AW+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
`ifdef TRDB_ENCAP_SRCID_EN
    S_SRCID   = 2'd2,
`endif
    S_PAYLOAD = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    byte_q, byte_d;
  logic          byte_valid_q, byte_valid_d;
  logic          last_q, last_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_cnt_q, drop_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [247:0]  payload_mem_q [FIFO_DEPTH];
  logic [4:0]    len_mem_q     [FIFO_DEPTH];

  logic          push_req, full, push, pop, drop;
  logic [AW-1:0] rd_nxt;
  logic [247:0]  head_pl;
  logic [4:0]    head_len, next_len, cnt_nx;
  logic          next_avail;

`ifndef TRDB_ENCAP_SRCID_EN
  logic unused_srcid;
  assign unused_srcid = ^SRC_ID;
`endif

  // FIFO handshake decode; a pop on the last byte frees a slot in the same cycle
  always_comb begin
    push_req   = packet_valid_i && (payload_length_i != 5'd0);
    full       = (count_q == DEPTH_C);
    pop        = byte_valid_q && byte_ready_i && last_q;
    push       = push_req && (!full || pop);
    drop       = push_req && full && !pop;
    rd_nxt     = rd_ptr_q + AW'(1);
    head_pl    = payload_mem_q[rd_ptr_q];
    head_len   = len_mem_q[rd_ptr_q];
    // next packet after a pop: already buffered, or bypassed from this cycle's push
    next_avail = (count_q > ONE_C) || push;
    next_len   = (count_q > ONE_C) ? len_mem_q[rd_nxt] : payload_length_i;
    cnt_nx     = cnt_q + 5'd1;
  end

  // FIFO pointer/occupancy and drop bookkeeping
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_nxt            : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
    overflow_d = drop;
    drop_cnt_d = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  // FIFO storage, written on accepted pushes only (contents need no reset)
  always_ff @(posedge clk_i) begin
    if (push) begin
      payload_mem_q[wr_ptr_q] <= packet_payload_i;
      len_mem_q[wr_ptr_q]     <= payload_length_i;
    end
  end

  // Next state and next presented byte; outputs are loaded on the transition
  always_comb begin
    state_d      = state_q;
    byte_d       = byte_q;
    byte_valid_d = byte_valid_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          state_d      = S_HEADER;
          byte_d       = {1'b0, FLOW, head_len};
          byte_valid_d = 1'b1;
          last_d       = 1'b0;
          cnt_d        = 5'd0;
        end
      end
      S_HEADER: begin
        if (byte_ready_i) begin
`ifdef TRDB_ENCAP_SRCID_EN
          state_d = S_SRCID;
          byte_d  = SRC_ID;
          last_d  = 1'b0;
`else
          state_d = S_PAYLOAD;
          byte_d  = head_pl[7:0];
          last_d  = (head_len == 5'd1);
`endif
        end
      end
`ifdef TRDB_ENCAP_SRCID_EN
      S_SRCID: begin
        if (byte_ready_i) begin
          state_d = S_PAYLOAD;
          byte_d  = head_pl[7:0];
          last_d  = (head_len == 5'd1);
        end
      end
`endif
      S_PAYLOAD: begin
        if (byte_ready_i) begin
          if (last_q) begin
            if (next_avail) begin
              state_d = S_HEADER;
              byte_d  = {1'b0, FLOW, next_len};
              last_d  = 1'b0;
              cnt_d   = 5'd0;
            end else begin
              state_d      = S_IDLE;
              byte_d       = 8'h00;
              byte_valid_d = 1'b0;
              last_d       = 1'b0;
            end
          end else begin
            cnt_d  = cnt_nx;
            byte_d = head_pl[{cnt_nx, 3'b000} +: 8];
            last_d = (cnt_nx == head_len - 5'd1);
          end
        end
      end
      default: begin
        state_d      = S_IDLE;
        byte_valid_d = 1'b0;
        last_d       = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any buffered or in-flight packet
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_IDLE;
      byte_q       <= 8'h00;
      byte_valid_q <= 1'b0;
      last_q       <= 1'b0;
      cnt_q        <= 5'd0;
      overflow_q   <= 1'b0;
      drop_cnt_q   <= 16'h0000;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      byte_q       <= byte_d;
      byte_valid_q <= byte_valid_d;
      last_q       <= last_d;
      cnt_q        <= cnt_d;
      overflow_q   <= overflow_d;
      drop_cnt_q   <= drop_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign byte_o       = byte_q;
  assign byte_valid_o = byte_valid_q;
  assign last_o       = last_q;
  assign overflow_o   = overflow_q;
  assign drop_count_o = drop_cnt_q;
  assign busy_o       = (count_q != '0) || (state_q != S_IDLE);

endmodule

// File: tb/tb_trdb_packet_encapsulator.sv
// Bench for trdb_packet_encapsulator: packet-level reference model plus directed scenarios.
module tb_trdb_packet_encapsulator;

`ifdef TRDB_ENCAP_SRCID_EN
  localparam logic [1:0] TB_FLOW = 2'b01;
  localparam logic [7:0] TB_SRC  = 8'h5A;
  localparam int         HDR_N   = 2;
`else
  localparam logic [1:0] TB_FLOW = 2'b00;
  localparam logic [7:0] TB_SRC  = 8'h00;
  localparam int         HDR_N   = 1;
`endif
  localparam int DEPTH = 2;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         packet_valid_i;
  logic [247:0] packet_payload_i;
  logic [4:0]   payload_length_i;
  logic [7:0]   byte_o;
  logic         byte_valid_o;
  logic         byte_ready_i;
  logic         last_o;
  logic         overflow_o;
  logic [15:0]  drop_count_o;
  logic         busy_o;

  trdb_packet_encapsulator #(.FIFO_DEPTH(DEPTH), .FLOW(TB_FLOW), .SRC_ID(TB_SRC)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .packet_valid_i(packet_valid_i),
    .packet_payload_i(packet_payload_i), .payload_length_i(payload_length_i),
    .byte_o(byte_o), .byte_valid_o(byte_valid_o), .byte_ready_i(byte_ready_i),
    .last_o(last_o), .overflow_o(overflow_o), .drop_count_o(drop_count_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, expv, $time);
    end
  endtask

  // ---------------- reference model: expected byte stream per packet ----------------
  typedef struct {
    logic [7:0] b;
    logic       l;
  } exp_t;
  exp_t        exp_q[$];
  int          occ;
  logic [15:0] m_drops;
  logic        ovf_exp;
  logic        stall_prev;
  logic [7:0]  prev_b;
  logic        prev_l;
  int          cyc = 0;
  int          ovf_seen = 0;
  logic [7:0]  log_b[$];
  int          log_c[$];

  // Inputs change just after posedge, so the negedge sees one stable cycle.
  always @(negedge clk_i) begin
    logic pop_now;
    cyc++;
    if (!rst_ni) begin
      exp_q.delete();
      occ = 0; m_drops = 16'h0; ovf_exp = 1'b0; stall_prev = 1'b0;
      check("reset_outputs", {byte_o, byte_valid_o, last_o, overflow_o, drop_count_o, busy_o}, 32'h0);
    end else begin
      if (overflow_o) ovf_seen++;
      check("overflow", overflow_o, ovf_exp);
      check("drop_count", drop_count_o, m_drops);
      check("busy", busy_o, occ != 0);
      if (stall_prev) check("hold", {byte_valid_o, byte_o, last_o}, {1'b1, prev_b, prev_l});
      pop_now = 1'b0;
      if (byte_valid_o) begin
        check("pending", exp_q.size() != 0, 1);
        if (byte_ready_i && exp_q.size() != 0) begin
          check("byte", byte_o, exp_q[0].b);
          check("last", last_o, exp_q[0].l);
          log_b.push_back(byte_o);
          log_c.push_back(cyc);
          pop_now = exp_q[0].l;
          void'(exp_q.pop_front());
        end
      end
      ovf_exp = 1'b0;
      if (packet_valid_i && payload_length_i != 5'd0) begin
        if (occ < DEPTH || pop_now) begin
          exp_q.push_back('{b: {1'b0, TB_FLOW, payload_length_i}, l: 1'b0});
`ifdef TRDB_ENCAP_SRCID_EN
          exp_q.push_back('{b: TB_SRC, l: 1'b0});
`endif
          for (int i = 0; i < int'(payload_length_i); i++)
            exp_q.push_back('{b: packet_payload_i[8*i +: 8], l: (i == int'(payload_length_i) - 1)});
          occ++;
        end else begin
          ovf_exp = 1'b1;
          if (m_drops != 16'hFFFF) m_drops = m_drops + 16'd1;
        end
      end
      if (pop_now) occ--;
      stall_prev = byte_valid_o && !byte_ready_i;
      prev_b = byte_o;
      prev_l = last_o;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic v, input logic [4:0] len, input logic [247:0] pl, input logic rdy);
    @(posedge clk_i); #1;
    packet_valid_i = v; payload_length_i = len; packet_payload_i = pl; byte_ready_i = rdy;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      if (exp_q.size() == 0 && !busy_o) break;
    end
    check("drained", (exp_q.size() == 0) && !busy_o, 1);
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk_i); #1;
      if (log_b.size() >= n) break;
    end
    check("log_reached", log_b.size() >= n, 1);
  endtask

  task automatic check_log(input string nm, input int base, input logic [7:0] e[$]);
    check({nm, "_count"}, log_b.size() - base, e.size());
    for (int i = 0; i < e.size(); i++)
      if (base + i < log_b.size()) check(nm, log_b[base + i], e[i]);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int ovf0;
    logic [7:0] e[$];
    rst_ni = 1'b0; packet_valid_i = 1'b0; packet_payload_i = '0;
    payload_length_i = 5'd0; byte_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    repeat (2) @(posedge clk_i);

    // 1: length 3, header at N+2
    base = log_b.size();
    drive(1'b1, 5'd3, 248'hCCBBAA, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    @(negedge clk_i); check("s1_lat_n1", byte_valid_o, 0);
    @(negedge clk_i);
`ifdef TRDB_ENCAP_SRCID_EN
    check("s1_lat_n2", {byte_valid_o, byte_o}, {1'b1, 8'h23});
    e = '{8'h23, 8'h5A, 8'hAA, 8'hBB, 8'hCC};
`else
    check("s1_lat_n2", {byte_valid_o, byte_o}, {1'b1, 8'h03});
    e = '{8'h03, 8'hAA, 8'hBB, 8'hCC};
`endif
    wait_idle();
    check_log("s1_bytes", base, e);

`ifdef TRDB_ENCAP_SRCID_EN
    // 2: source-ID byte after header
    base = log_b.size();
    drive(1'b1, 5'd1, 248'h11, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    wait_idle();
    e = '{8'h21, 8'h5A, 8'h11};
    check_log("s2_bytes", base, e);
`endif

    // 3: sink stall of 10 cycles mid-payload
    base = log_b.size();
    drive(1'b1, 5'd6, 248'h060504030201, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    wait_log(base + 3);
    byte_ready_i = 1'b0;
    repeat (10) @(posedge clk_i);
    #1;
`ifdef TRDB_ENCAP_SRCID_EN
    check("s3_stalled_byte", byte_o, 8'h02);
    e = '{8'h26, 8'h5A, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`else
    check("s3_stalled_byte", byte_o, 8'h03);
    e = '{8'h06, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
`endif
    byte_ready_i = 1'b1;
    wait_idle();
    check_log("s3_bytes", base, e);

    // 4: stalled sink, three pushes into a 2-deep FIFO
    base = log_b.size();
    ovf0 = ovf_seen;
    drive(1'b1, 5'd2, 248'h0B0A, 1'b0);
    drive(1'b1, 5'd2, 248'h1B1A, 1'b0);
    drive(1'b1, 5'd2, 248'h2B2A, 1'b0);
    repeat (4) drive(1'b0, 5'd0, '0, 1'b0);
    check("s4_drop_count", drop_count_o, 16'd1);
    check("s4_ovf_pulses", ovf_seen - ovf0, 1);
    drive(1'b0, 5'd0, '0, 1'b1);
    wait_idle();
`ifdef TRDB_ENCAP_SRCID_EN
    e = '{8'h22, 8'h5A, 8'h0A, 8'h0B, 8'h22, 8'h5A, 8'h1A, 8'h1B};
`else
    e = '{8'h02, 8'h0A, 8'h0B, 8'h02, 8'h1A, 8'h1B};
`endif
    check_log("s4_bytes", base, e);
    if (log_b.size() == base + e.size())
      check("s4_back_to_back", log_c[base + e.size() - 1] - log_c[base], e.size() - 1);

    // 5: push on a full FIFO in the cycle the head packet pops
    base = log_b.size();
    drive(1'b1, 5'd1, 248'h31, 1'b0);
    drive(1'b1, 5'd1, 248'h32, 1'b0);
    repeat (3) drive(1'b0, 5'd0, '0, 1'b0);
    drive(1'b0, 5'd0, '0, 1'b1);
`ifdef TRDB_ENCAP_SRCID_EN
    drive(1'b0, 5'd0, '0, 1'b1);
`endif
    drive(1'b1, 5'd1, 248'h33, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    wait_idle();
    check("s5_drop_count", drop_count_o, 16'd1);
`ifdef TRDB_ENCAP_SRCID_EN
    e = '{8'h21, 8'h5A, 8'h31, 8'h21, 8'h5A, 8'h32, 8'h21, 8'h5A, 8'h33};
`else
    e = '{8'h01, 8'h31, 8'h01, 8'h32, 8'h01, 8'h33};
`endif
    check_log("s5_bytes", base, e);

    // 6: zero-length push is ignored
    base = log_b.size();
    drive(1'b1, 5'd0, 248'hFF, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    repeat (5) begin
      @(negedge clk_i);
      check("s6_busy", busy_o, 0);
      check("s6_valid", byte_valid_o, 0);
    end
    check("s6_drop_count", drop_count_o, 16'd1);
    check("s6_no_bytes", log_b.size() - base, 0);

    // 7: reset after the second payload byte of a length-5 packet
    base = log_b.size();
    drive(1'b1, 5'd5, 248'h1413121110, 1'b1);
    drive(1'b0, 5'd0, '0, 1'b1);
    wait_log(base + HDR_N + 2);
    rst_ni = 1'b0;
    #1;
    check("s7_rst_outputs", {byte_o, byte_valid_o, last_o, overflow_o, busy_o}, 32'h0);
    check("s7_rst_drops", drop_count_o, 16'h0);
    repeat (2) @(posedge clk_i);
    #1 rst_ni = 1'b1;
    base = log_b.size();
    repeat (20) @(posedge clk_i);
    #1;
    check("s7_no_bytes", log_b.size() - base, 0);
    check("s7_busy", busy_o, 0);
    check("s7_valid", byte_valid_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
